fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Small first-word-fall-through instruction queue between the instruction-fetch stage and the decode stage of the 32-bit pipeline.
- Buffers (PC, instruction) pairs produced by fetch, so a decode stall does not immediately stall fetch.
- Drives the fetch-stage freeze when full.
- Discards all buffered entries on a taken branch (flush).

Parameters:
- DATA_WIDTH, 32, width of PC and instruction words.
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_WIDTH, 3, width of occupancy count; equals log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  fetch presents a valid pair this cycle
- in_pc  input  DATA_WIDTH  PC of the fetched instruction
- in_instruction  input  DATA_WIDTH  fetched instruction word
- freeze_fetch  output  1  high when the queue cannot accept a push (full); drives the fetch-stage freeze
- flush  input  1  taken branch; discard all entries
- out_ready  input  1  decode consumes the head entry this cycle
- out_valid  output  1  head entry is valid
- out_pc  output  DATA_WIDTH  head entry PC
- out_instruction  output  DATA_WIDTH  head entry instruction; 0 when empty
- count  output  CNT_WIDTH  current occupancy, 0..DEPTH
- flush_drops  output  16  count of valid entries discarded by flushes (see Optional Feature)

Behaviour:
- Clock and reset: one clock. clk is the clock; reset is synchronous and active-high.
- Reset (sampled high at a clk edge), which has priority over everything:
  - rd_ptr = wr_ptr = 0 and count = 0.
  - out_valid = 0, freeze_fetch = 0, out_pc = 0, out_instruction = 0, flush_drops = 0.
  - Storage contents are don't-care.
- Status outputs:
  - freeze_fetch = (count == DEPTH), decoded from registered count; purely a function of state.
  - out_valid = (count != 0).
  - out_pc and out_instruction show storage[rd_ptr] while out_valid = 1, and 0 otherwise.
- Push: occurs when in_valid && !freeze_fetch && !flush. Writes storage[wr_ptr], then wr_ptr increments modulo DEPTH.
- Pop: occurs when out_ready && out_valid && !flush. rd_ptr increments modulo DEPTH.
  - out_ready while empty is ignored.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- Full with simultaneous pop: the push is still refused, because freeze_fetch is registered state. The entry is lost unless fetch holds it; fetch holds its PC while frozen.
- Latency:
  - A pair pushed at edge N appears on outputs after edge N if the queue was empty; first-word-fall-through, one cycle.
  - No combinational in->out bypass.
- Flush, when reset is low:
  - At the edge: rd_ptr = wr_ptr = 0, count = 0.
  - Any same-cycle push or pop is ignored.
  - out_valid = 0 from the next cycle.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH and never goes below 0.
- Reset mid-operation: everything clears at that edge, including in-flight push, pop and flush.

Optional Feature:
- Macro: FDQ_FLUSH_STATS_EN.
- Defined:
  - flush_drops is a 16-bit saturating counter.
  - On each flush edge (reset low), it adds the count value just before the flush; it saturates at 16'hFFFF.
  - Reset clears it to 0.
- Not defined: flush_drops is tied to 16'd0 and no counter logic is generated.

Test Plan:
- Reset, then push pc=0x00,04,08,0C with out_ready=0:
  - count goes 1,2,3,4.
  - freeze_fetch=1 after the 4th edge.
  - A 5th push (pc=0x10) is refused; count stays 4.
- Full queue, then out_ready=1 and in_valid=1 for one cycle:
  - Pop only; count=3, out_pc=0x04.
  - Next cycle the push of 0x10 is accepted; count stays 3.
- Empty queue, push pc=0x20/instr=0xDEADBEEF at edge N:
  - out_valid=1 with those values right after edge N.
  - out_ready=1 pops it; count=0 and out_instruction=0.
- Queue holding 3 entries, flush=1 with in_valid=1 and out_ready=1:
  - Next cycle count=0, out_valid=0, no entry written.
  - With FDQ_FLUSH_STATS_EN, flush_drops=3.
- Wrap-around: 10 alternating push/pop pairs at count=2:
  - Output order matches input order (pc increments by 4).
  - count stays 2.
- reset=1 while count=2 and flush=1:
  - All outputs return to their reset values.
  - flush_drops=0 (reset has priority over flush).

Source files
------------

// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//
// First-word-fall-through queue of (PC, instruction) pairs sitting between the
// instruction-fetch and decode stages. Absorbs decode stalls, freezes fetch
// when full and drops everything on a taken branch.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset (priority over everything)
//   in_valid        fetch presents a pair this cycle
//   in_pc           PC of the fetched instruction
//   in_instruction  fetched instruction word
//   freeze_fetch    queue full; fetch must hold its current pair
//   flush           taken branch; discard all entries
//   out_ready       decode consumes the head entry this cycle
//   out_valid       head entry is valid
//   out_pc          head entry PC (0 when empty)
//   out_instruction head entry instruction (0 when empty)
//   count           occupancy, 0..DEPTH
//   flush_drops     saturating count of entries discarded by flushes
//
// Build option:
//   FDQ_FLUSH_STATS_EN  when defined, flush_drops is a 16-bit saturating
//                       counter; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module fetch_decode_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_instruction,
    output logic                  freeze_fetch,
    input  logic                  flush,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [CNT_WIDTH-1:0]  count,
    output logic [15:0]           flush_drops
);

    localparam int                   PTR_WIDTH  = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];

    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 push;
    logic                 pop;

    // Status is decoded from registered occupancy only, so a same-cycle pop
    // never opens a slot for the push: fetch holds the pair while frozen.
    assign freeze_fetch = (count_q == FULL_COUNT);
    assign out_valid    = (count_q != '0);
    assign count        = count_q;

    assign push = in_valid && !freeze_fetch && !flush;
    assign pop  = out_ready && out_valid && !flush;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; unread slots are never observed because the output is masked by out_valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instruction;
        end
    end

    assign out_pc          = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign out_instruction = out_valid ? instr_mem_q[rd_ptr_q] : '0;

`ifdef FDQ_FLUSH_STATS_EN
    logic [15:0] flush_drops_q, flush_drops_d;
    logic [16:0] drops_sum;

    // One extra bit catches the overflow used for saturation.
    assign drops_sum = {1'b0, flush_drops_q} + 17'(count_q);

    always_comb begin
        flush_drops_d = flush_drops_q;
        if (flush) begin
            flush_drops_d = drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_drops_q <= '0;
        end else begin
            flush_drops_q <= flush_drops_d;
        end
    end

    assign flush_drops = flush_drops_q;
`else
    assign flush_drops = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_queue
//
// Self-checking bench for fetch_decode_queue. A scoreboard queue receives each
// pair the bench expects to be accepted; entries are popped and compared when
// decode consumes the head. Occupancy, status and flush statistics come from a
// small reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_fetch_decode_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

`ifdef FDQ_FLUSH_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_pc;
    logic [DW-1:0] in_instruction;
    logic          freeze_fetch;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_pc;
    logic [DW-1:0] out_instruction;
    logic [CW-1:0] count;
    logic [15:0]   flush_drops;

    entry_t sb[$];
    int     m_count;
    int     m_drops;
    int     checks;
    int     errors;

    fetch_decode_queue #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_instruction (in_instruction),
        .freeze_fetch   (freeze_fetch),
        .flush          (flush),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instruction(out_instruction),
        .count          (count),
        .flush_drops    (flush_drops)
    );

    always #5 clk = ~clk;

    // Drives one clock cycle: inputs are applied 1 time unit after the
    // previous edge, the head is compared before the edge when a pop is due,
    // and status is sampled 1 time unit after the edge.
    task automatic cycle(input logic rst, input logic v, input logic [DW-1:0] pc,
                         input logic [DW-1:0] ins, input logic rdy, input logic fl);
        bit     do_push;
        bit     do_pop;
        entry_t e;
        logic [15:0] exp_drops;

        reset          = rst;
        in_valid       = v;
        in_pc          = pc;
        in_instruction = ins;
        out_ready      = rdy;
        flush          = fl;
        #1;

        do_push = !rst && !fl && v && (m_count != DEPTH);
        do_pop  = !rst && !fl && rdy && (m_count != 0);

        if (do_pop) begin
            e = sb.pop_front();
            checks++;
            if (out_pc !== e.pc || out_instruction !== e.instr) begin
                errors++;
                $display("FAIL pop_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                         out_pc, out_instruction, e.pc, e.instr);
            end
        end

        if (rst) begin
            sb.delete();
            m_count = 0;
            m_drops = 0;
        end else if (fl) begin
            m_drops = (m_drops + m_count > 65535) ? 65535 : m_drops + m_count;
            sb.delete();
            m_count = 0;
        end else begin
            if (do_push) sb.push_back('{pc: pc, instr: ins});
            m_count = m_count + int'(do_push) - int'(do_pop);
        end

        @(posedge clk);
        #1;

        checks++;
        if (count !== CW'(m_count)) begin
            errors++;
            $display("FAIL count: got %0d, expected %0d", count, m_count);
        end
        checks++;
        if (out_valid !== (m_count != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b, expected %b", out_valid, m_count != 0);
        end
        checks++;
        if (freeze_fetch !== (m_count == DEPTH)) begin
            errors++;
            $display("FAIL freeze_fetch: got %b, expected %b", freeze_fetch, m_count == DEPTH);
        end
        exp_drops = STATS_EN ? 16'(m_drops) : 16'd0;
        checks++;
        if (flush_drops !== exp_drops) begin
            errors++;
            $display("FAIL flush_drops: got %0d, expected %0d", flush_drops, exp_drops);
        end
        if (m_count == 0) begin
            checks++;
            if (out_pc !== '0 || out_instruction !== '0) begin
                errors++;
                $display("FAIL empty_outputs: got pc=%h instr=%h, expected 0/0",
                         out_pc, out_instruction);
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH && m_count != 0; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 32'h55, 32'h66, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 32'(i * 4), 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
        end
        checks++;
        if (freeze_fetch !== 1'b1) begin
            errors++;
            $display("FAIL fill_freeze: got %b, expected 1", freeze_fetch);
        end
        // Fifth push must be refused while full.
        cycle(1'b0, 1'b1, 32'h10, 32'h1010, 1'b0, 1'b0);
        checks++;
        if (out_pc !== 32'h0) begin
            errors++;
            $display("FAIL fill_head: got pc=%h, expected 00000000", out_pc);
        end
    endtask

    task automatic test_full_pop();
        cycle(1'b0, 1'b1, 32'h10, 32'h1010, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd3 || out_pc !== 32'h04) begin
            errors++;
            $display("FAIL full_pop: got count=%0d pc=%h, expected 3/00000004", count, out_pc);
        end
        cycle(1'b0, 1'b1, 32'h10, 32'h1010, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL full_pop_push: got count=%0d, expected 3", count);
        end
        drain();
    endtask

    task automatic test_fwft();
        cycle(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instruction !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fwft: got v=%b pc=%h instr=%h, expected 1/00000020/deadbeef",
                     out_valid, out_pc, out_instruction);
        end
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        // Pop while empty must be ignored.
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 32'h40 + 32'(i * 4), 32'hA000 + 32'(i), 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b1, 32'h80, 32'hBAD, 1'b1, 1'b1);
        idle();
        // Queue must accept fresh entries after the flush, starting from slot 0.
        cycle(1'b0, 1'b1, 32'h90, 32'hC0DE, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] pc;
        pc = 32'h100;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, pc, ~pc, 1'b0, 1'b0);
            pc += 4;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, pc, ~pc, 1'b1, 1'b0);
            pc += 4;
        end
        drain();
    endtask

    task automatic test_reset_priority();
        cycle(1'b0, 1'b1, 32'h200, 32'h1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h204, 32'h2, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h208, 32'h3, 1'b1, 1'b1);
        checks++;
        if (flush_drops !== 16'd0 || out_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL reset_priority: got drops=%0d v=%b count=%0d, expected 0/0/0",
                     flush_drops, out_valid, count);
        end
        idle();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        m_count        = 0;
        m_drops        = 0;
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_pc          = '0;
        in_instruction = '0;
        flush          = 1'b0;
        out_ready      = 1'b0;
        @(posedge clk);
        #1;

        test_reset();
        test_fill();
        test_full_pop();
        test_fwft();
        test_flush();
        test_back_to_back();
        test_reset_priority();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
